// File: rtl/ext_mem_slave_if.sv
// ext_mem_slave_if: two-sided memory bus between the accelerator (master) and an
// external memory slave.
//   Mout_oe_ram / Mout_we_ram    per-channel read / write request
//   Mout_addr_ram                per-channel byte address (ADDR_W bits each)
//   Mout_Wdata_ram               per-channel write byte
//   Mout_data_ram_size           per-channel access width in bits (SIZE_W bits each)
//   Sout_Rdata_ram / Sout_DataRdy accelerator slave-side response, merged by the slave
//   M_Rdata_ram / M_DataRdy      merged response returned to the master
interface ext_mem_slave_if #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned SIZE_W   = 4
);
    logic [CHANNELS-1:0]        Mout_oe_ram;
    logic [CHANNELS-1:0]        Mout_we_ram;
    logic [CHANNELS*ADDR_W-1:0] Mout_addr_ram;
    logic [CHANNELS*8-1:0]      Mout_Wdata_ram;
    logic [CHANNELS*SIZE_W-1:0] Mout_data_ram_size;
    logic [CHANNELS*8-1:0]      Sout_Rdata_ram;
    logic [CHANNELS-1:0]        Sout_DataRdy;
    logic [CHANNELS*8-1:0]      M_Rdata_ram;
    logic [CHANNELS-1:0]        M_DataRdy;

    modport master (
        output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
        output Sout_Rdata_ram, Sout_DataRdy,
        input  M_Rdata_ram, M_DataRdy
    );

    modport slave (
        input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
        input  Sout_Rdata_ram, Sout_DataRdy,
        output M_Rdata_ram, M_DataRdy
    );
endinterface

// File: rtl/ext_mem_slave.sv
// ext_mem_slave: external byte memory serving the accelerator's multi-channel master bus
// with programmable read/write latency, merging its responses with the accelerator's
// own slave-side responses.
// Ports:
//   clock         rising-edge clock
//   reset         synchronous active-high reset (memory contents are kept)
//   bus           slave side of ext_mem_slave_if (requests in, merged responses out)
//   load_en       backdoor preload strobe; load_addr is relative to BASE_ADDR
//   load_addr     preload address
//   load_data     preload byte
//   err_conflict  per-channel sticky flag: read and write requested together
module ext_mem_slave #(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned SIZE_W      = 4,
    parameter int unsigned MEMSIZE     = 32,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned READ_DELAY  = 2,
    parameter int unsigned WRITE_DELAY = 1
) (
    input  logic                clock,
    input  logic                reset,
    ext_mem_slave_if.slave      bus,
    input  logic                load_en,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [7:0]          load_data,
    output logic [CHANNELS-1:0] err_conflict
);

    localparam int unsigned IdxW     = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
    localparam int unsigned MaxDelay = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
    localparam int unsigned CntW     = $clog2(MaxDelay + 1);
    localparam logic [CntW-1:0] RdLast = CntW'(READ_DELAY - 1);
    localparam logic [CntW-1:0] WrLast = CntW'(WRITE_DELAY - 1);

    typedef enum logic {StIdle, StBusy} state_e;

    // Byte mask for a write of `size` bits: 0 keeps the byte, 8 or more replaces it.
    function automatic logic [7:0] size_mask(input logic [SIZE_W-1:0] size);
        if (32'(size) >= 32'd8) begin
            return 8'hFF;
        end
        return 8'hFF >> (32'd8 - 32'(size));
    endfunction

    logic [7:0]          mem_q [MEMSIZE];
    logic [CHANNELS-1:0] wr_commit;
    logic [IdxW-1:0]     wr_idx  [CHANNELS];
    logic [7:0]          wr_data [CHANNELS];
    logic [7:0]          wr_mask [CHANNELS];
    logic [CHANNELS-1:0] err_q, err_d;
    logic                load_in_range;
    logic [IdxW-1:0]     load_idx;

    assign err_d        = err_q | (bus.Mout_oe_ram & bus.Mout_we_ram);
    assign err_conflict = err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign load_in_range = 32'(load_addr) < MEMSIZE;
    assign load_idx      = IdxW'(load_addr);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [ADDR_W-1:0] addr;
        logic [31:0]       offset;
        logic [IdxW-1:0]   idx;
        logic              in_range, rd_req, wr_req, held;
        logic              ready, commit;
        logic [7:0]        rd_byte, rd_local;
        state_e            state_q, state_d;
        logic [CntW-1:0]   cnt_q, cnt_d, cnt_last;
        logic              is_wr_q, is_wr_d;

        assign addr   = bus.Mout_addr_ram[c*ADDR_W +: ADDR_W];
        // Addresses below BASE_ADDR wrap to a huge offset and fall out of range.
        assign offset   = 32'(addr) - BASE_ADDR;
        assign in_range = offset < MEMSIZE;
        assign idx      = IdxW'(offset);

        // A conflicting oe+we pair is treated as no request at all.
        assign rd_req   = bus.Mout_oe_ram[c] & ~bus.Mout_we_ram[c] & in_range;
        assign wr_req   = bus.Mout_we_ram[c] & ~bus.Mout_oe_ram[c] & in_range;
        assign held     = is_wr_q ? wr_req : rd_req;
        assign cnt_last = is_wr_q ? WrLast : RdLast;

        always_ff @(posedge clock) begin
            if (reset) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                is_wr_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                is_wr_q <= is_wr_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            is_wr_d = is_wr_q;
            unique case (state_q)
                StIdle: begin
                    if (rd_req) begin
                        if (READ_DELAY > 1) begin
                            state_d = StBusy;
                            cnt_d   = CntW'(1);
                            is_wr_d = 1'b0;
                        end
                    end else if (wr_req) begin
                        if (WRITE_DELAY > 1) begin
                            state_d = StBusy;
                            cnt_d   = CntW'(1);
                            is_wr_d = 1'b1;
                        end
                    end
                end
                StBusy: begin
                    if (!held || cnt_q == cnt_last) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            endcase
        end

        always_comb begin
            ready  = 1'b0;
            commit = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (rd_req && READ_DELAY == 1) begin
                        ready = 1'b1;
                    end else if (wr_req && WRITE_DELAY == 1) begin
                        ready  = 1'b1;
                        commit = 1'b1;
                    end
                end
                StBusy: begin
                    if (held && cnt_q == cnt_last) begin
                        ready  = 1'b1;
                        commit = is_wr_q;
                    end
                end
            endcase
            // A reset landing on the completion cycle still aborts the access.
            if (reset) begin
                ready  = 1'b0;
                commit = 1'b0;
            end
        end

        assign rd_byte = rd_req ? mem_q[idx] : 8'h00;

        if (READ_DELAY == 1) begin : g_rd_comb
            assign rd_local = rd_byte;
        end else begin : g_rd_pipe
            logic [7:0] pipe_q [READ_DELAY-1];
            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int i = 0; i < int'(READ_DELAY) - 1; i++) begin
                        pipe_q[i] <= 8'h00;
                    end
                end else begin
                    pipe_q[0] <= rd_byte;
                    for (int i = 1; i < int'(READ_DELAY) - 1; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end
            assign rd_local = pipe_q[READ_DELAY-2];
        end

        assign bus.M_DataRdy[c]          = bus.Sout_DataRdy[c] | ready;
        assign bus.M_Rdata_ram[c*8 +: 8] = rd_local | bus.Sout_Rdata_ram[c*8 +: 8];

        assign wr_commit[c] = commit;
        assign wr_idx[c]    = idx;
        assign wr_data[c]   = bus.Mout_Wdata_ram[c*8 +: 8];
        assign wr_mask[c]   = size_mask(bus.Mout_data_ram_size[c*SIZE_W +: SIZE_W]);
    end

    // Later channels overwrite earlier ones on the same byte; preload overrides all.
    always_ff @(posedge clock) begin
        for (int c = 0; c < int'(CHANNELS); c++) begin
            if (wr_commit[c]) begin
                mem_q[wr_idx[c]] <= (wr_data[c] & wr_mask[c]) | (mem_q[wr_idx[c]] & ~wr_mask[c]);
            end
        end
        if (load_en && load_in_range) begin
            mem_q[load_idx] <= load_data;
        end
    end

endmodule

// File: tb/tb_ext_mem_slave.sv
module tb_ext_mem_slave;

    logic       clock = 1'b0;
    logic       reset;
    logic       load_en;
    logic [6:0] load_addr;
    logic [7:0] load_data;
    logic [1:0] err_a, err_b;

    always #5 clock = ~clock;

    ext_mem_slave_if #(.CHANNELS(2), .ADDR_W(7), .SIZE_W(4)) ifa ();
    ext_mem_slave_if #(.CHANNELS(2), .ADDR_W(7), .SIZE_W(4)) ifb ();

    ext_mem_slave #(
        .CHANNELS(2), .ADDR_W(7), .SIZE_W(4), .MEMSIZE(32), .BASE_ADDR(0),
        .READ_DELAY(2), .WRITE_DELAY(1)
    ) u_dut_a (
        .clock(clock), .reset(reset), .bus(ifa), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .err_conflict(err_a)
    );

    ext_mem_slave #(
        .CHANNELS(2), .ADDR_W(7), .SIZE_W(4), .MEMSIZE(32), .BASE_ADDR(0),
        .READ_DELAY(4), .WRITE_DELAY(1)
    ) u_dut_b (
        .clock(clock), .reset(reset), .bus(ifb), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .err_conflict(err_b)
    );

    typedef struct {
        int         dut;
        int         ch;
        logic [7:0] data;
        bit         chk_data;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Scoreboard monitor: every asserted ready must match the oldest expectation for
    // that DUT/channel, in cycle and (for reads) in data.
    exp_t       item;
    int         found;
    logic       rdy;
    logic [7:0] rdat;
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                rdy  = (d == 0) ? ifa.M_DataRdy[c] : ifb.M_DataRdy[c];
                rdat = (d == 0) ? ifa.M_Rdata_ram[c*8 +: 8] : ifb.M_Rdata_ram[c*8 +: 8];
                if (rdy !== 1'b0) begin
                    found = -1;
                    foreach (exp_q[i]) begin
                        if (found < 0 && exp_q[i].dut == d && exp_q[i].ch == c) found = i;
                    end
                    if (found < 0) begin
                        n_total++;
                        $display("FAIL unexpected_ready dut%0d ch%0d: got ready=%b, required 0 (cycle %0d)",
                                 d, c, rdy, cyc);
                    end else begin
                        item = exp_q[found];
                        exp_q.delete(found);
                        check($sformatf("ready_cycle_d%0d_ch%0d", d, c), cyc, item.cyc);
                        if (item.chk_data)
                            check($sformatf("rdata_d%0d_ch%0d", d, c), 32'(rdat), 32'(item.data));
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic bus_idle();
        ifa.Mout_oe_ram = '0; ifa.Mout_we_ram = '0; ifa.Mout_addr_ram = '0;
        ifa.Mout_Wdata_ram = '0; ifa.Mout_data_ram_size = '0;
        ifa.Sout_Rdata_ram = '0; ifa.Sout_DataRdy = '0;
        ifb.Mout_oe_ram = '0; ifb.Mout_we_ram = '0; ifb.Mout_addr_ram = '0;
        ifb.Mout_Wdata_ram = '0; ifb.Mout_data_ram_size = '0;
        ifb.Sout_Rdata_ram = '0; ifb.Sout_DataRdy = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
    endtask

    task automatic preload(input int a, input int d);
        load_en = 1'b1; load_addr = 7'(a); load_data = 8'(d);
        step(1);
        load_en = 1'b0;
    endtask

    task automatic read_a(input int ch, input int addr, input int req);
        ifa.Mout_oe_ram[ch] = 1'b1;
        ifa.Mout_addr_ram[ch*7 +: 7] = 7'(addr);
        exp_q.push_back('{dut: 0, ch: ch, data: 8'(req), chk_data: 1'b1, cyc: cyc + 1});
        step(2);
        ifa.Mout_oe_ram[ch] = 1'b0;
    endtask

    task automatic read_b(input int ch, input int addr, input int req);
        ifb.Mout_oe_ram[ch] = 1'b1;
        ifb.Mout_addr_ram[ch*7 +: 7] = 7'(addr);
        exp_q.push_back('{dut: 1, ch: ch, data: 8'(req), chk_data: 1'b1, cyc: cyc + 3});
        step(4);
        ifb.Mout_oe_ram[ch] = 1'b0;
    endtask

    task automatic set_wr_a(input int ch, input int addr, input int data, input int size);
        ifa.Mout_we_ram[ch] = 1'b1;
        ifa.Mout_addr_ram[ch*7 +: 7] = 7'(addr);
        ifa.Mout_Wdata_ram[ch*8 +: 8] = 8'(data);
        ifa.Mout_data_ram_size[ch*4 +: 4] = 4'(size);
        exp_q.push_back('{dut: 0, ch: ch, data: 8'h00, chk_data: 1'b0, cyc: cyc});
    endtask

    task automatic write_a(input int ch, input int addr, input int data, input int size);
        set_wr_a(ch, addr, data, size);
        step(1);
        ifa.Mout_we_ram[ch] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus_idle();
        ifa.Sout_Rdata_ram = 16'hC35A;
        ifb.Sout_Rdata_ram = 16'h3CA5;
        step(3);
        check("rst_rdata_a", 32'(ifa.M_Rdata_ram), 32'h0000C35A);
        check("rst_rdy_a", 32'(ifa.M_DataRdy), 32'h0);
        check("rst_err_a", 32'(err_a), 32'h0);
        check("rst_rdata_b", 32'(ifb.M_Rdata_ram), 32'h00003CA5);
        check("rst_rdy_b", 32'(ifb.M_DataRdy), 32'h0);
        check("rst_err_b", 32'(err_b), 32'h0);
        bus_idle();
        reset = 1'b0;
        step(1);

        preload(5, 8'hA7);
        preload(6, 8'h5A);
        preload(8, 8'h80);
        preload(37, 8'h00);           // beyond MEMSIZE: must not alias onto byte 5
        read_a(0, 5, 8'hA7);
        step(1);

        write_a(1, 3, 8'h3C, 8);
        read_a(0, 3, 8'h3C);
        preload(3, 8'hFF);
        write_a(1, 3, 8'h3C, 4);
        read_a(1, 3, 8'hFC);
        write_a(0, 6, 8'h00, 0);
        read_a(0, 6, 8'h5A);

        // Both channels reading the same byte.
        ifa.Mout_oe_ram = 2'b11;
        ifa.Mout_addr_ram = {7'd5, 7'd5};
        exp_q.push_back('{dut: 0, ch: 0, data: 8'hA7, chk_data: 1'b1, cyc: cyc + 1});
        exp_q.push_back('{dut: 0, ch: 1, data: 8'hA7, chk_data: 1'b1, cyc: cyc + 1});
        step(2);
        ifa.Mout_oe_ram = 2'b00;

        // Two writes to one byte in the same cycle: channel 1 wins.
        set_wr_a(0, 7, 8'h11, 8);
        set_wr_a(1, 7, 8'h22, 8);
        step(1);
        ifa.Mout_we_ram = 2'b00;
        read_a(0, 7, 8'h22);

        // Read and write of one byte in the same cycle: read sees old data.
        ifa.Mout_oe_ram[0] = 1'b1;
        ifa.Mout_addr_ram[6:0] = 7'd7;
        exp_q.push_back('{dut: 0, ch: 0, data: 8'h22, chk_data: 1'b1, cyc: cyc + 1});
        set_wr_a(1, 7, 8'h33, 8);
        step(1);
        ifa.Mout_we_ram[1] = 1'b0;
        step(1);
        ifa.Mout_oe_ram[0] = 1'b0;
        read_a(1, 7, 8'h33);

        // Out of range: only the accelerator's slave-side response comes through.
        ifa.Mout_oe_ram[0] = 1'b1;
        ifa.Mout_addr_ram[6:0] = 7'd40;
        step(1);
        ifa.Sout_DataRdy[0] = 1'b1;
        ifa.Sout_Rdata_ram[7:0] = 8'h11;
        exp_q.push_back('{dut: 0, ch: 0, data: 8'h11, chk_data: 1'b1, cyc: cyc});
        step(1);
        ifa.Sout_DataRdy[0] = 1'b0;
        ifa.Sout_Rdata_ram[7:0] = 8'h00;
        #1;
        check("oor_local_data", 32'(ifa.M_Rdata_ram[7:0]), 32'h0);
        step(2);
        ifa.Mout_oe_ram[0] = 1'b0;
        step(1);

        // Conflict: sticky flag, no access, no ready.
        ifa.Mout_oe_ram[0] = 1'b1;
        ifa.Mout_we_ram[0] = 1'b1;
        ifa.Mout_addr_ram[6:0] = 7'd5;
        ifa.Mout_Wdata_ram[7:0] = 8'h00;
        ifa.Mout_data_ram_size[3:0] = 4'd8;
        step(1);
        check("conflict_flag", 32'(err_a), 32'h1);
        step(1);
        ifa.Mout_oe_ram[0] = 1'b0;
        ifa.Mout_we_ram[0] = 1'b0;
        read_a(0, 5, 8'hA7);
        step(3);
        check("conflict_sticky", 32'(err_a), 32'h1);
        check("conflict_other_dut", 32'(err_b), 32'h0);

        // Long latency read on the READ_DELAY=4 instance.
        read_b(0, 5, 8'hA7);
        step(1);

        // Request dropped in BUSY: no ready ever.
        ifb.Mout_oe_ram[0] = 1'b1;
        ifb.Mout_addr_ram[6:0] = 7'd5;
        step(2);
        ifb.Mout_oe_ram[0] = 1'b0;
        step(5);

        // Reset mid-transaction: abort, then a fresh read completes.
        ifb.Mout_oe_ram[0] = 1'b1;
        ifb.Mout_addr_ram[6:0] = 7'd5;
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        ifb.Mout_oe_ram[0] = 1'b0;
        step(3);
        check("err_cleared_by_reset", 32'(err_a), 32'h0);
        read_b(0, 6, 8'h5A);
        step(4);

        check("sb_drain", 32'(exp_q.size()), 32'h0);
        foreach (exp_q[i])
            $display("pending: dut%0d ch%0d expected ready at cycle %0d never seen",
                     exp_q[i].dut, exp_q[i].ch, exp_q[i].cyc);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ext_mem_slave.md
# ext_mem_slave

Synthesizable off-chip memory slave for the Bambu-generated `main` accelerator's two-channel master memory bus (`Mout_*` / `M_*`). It sits directly downstream of `main`: it accepts per-channel read/write requests, serves them from an internal byte array with programmable read/write latency, and merges its responses with the accelerator's own slave-side responses (`Sout_*`). Simulation benches and FPGA bring-up use it as the external memory that `main` reads and sorts in place.

## Interface
Parameters:
- `CHANNELS`, 2, number of independent bus channels
- `ADDR_W`, 7, address bits per channel
- `SIZE_W`, 4, size-field bits per channel (access width in bits)
- `MEMSIZE`, 32, bytes of backing store
- `BASE_ADDR`, 0, first byte address served; the window is `[BASE_ADDR, BASE_ADDR+MEMSIZE)`
- `READ_DELAY`, 2, read latency parameter, ≥1
- `WRITE_DELAY`, 1, write latency parameter, ≥1

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high
- `Mout_oe_ram`  in  CHANNELS  read request, one bit per channel
- `Mout_we_ram`  in  CHANNELS  write request, one bit per channel
- `Mout_addr_ram`  in  CHANNELS*ADDR_W  byte address; channel c uses slice `[c*ADDR_W +: ADDR_W]`
- `Mout_Wdata_ram`  in  CHANNELS*8  write byte per channel
- `Mout_data_ram_size`  in  CHANNELS*SIZE_W  access width in bits per channel
- `Sout_Rdata_ram`  in  CHANNELS*8  read data from the accelerator's slave side
- `Sout_DataRdy`  in  CHANNELS  ready from the accelerator's slave side
- `load_en`  in  1  backdoor preload strobe
- `load_addr`  in  ADDR_W  preload address, relative to `BASE_ADDR`
- `load_data`  in  8  preload byte
- `M_Rdata_ram`  out  CHANNELS*8  read data returned to the master
- `M_DataRdy`  out  CHANNELS  transfer complete, one bit per channel
- `err_conflict`  out  CHANNELS  sticky flag: `oe` and `we` were asserted together on that channel

## Operation
- A request is in range when `BASE_ADDR <= addr < BASE_ADDR+MEMSIZE`. The array index is `addr - BASE_ADDR`.
- Out-of-range requests are ignored:
  - no array access and no counter change;
  - the local contribution to `M_Rdata_ram` and `M_DataRdy` is 0.
- Each channel has its own FSM:
  - **IDLE**: an in-range `oe` or `we` moves the channel to **BUSY** with `cnt=1`. If the configured delay is 1, the request completes this cycle instead.
  - **BUSY**: `cnt` increments each cycle while the same request type is held. When `cnt == DELAY-1`, `M_DataRdy[c]` is asserted and the channel returns to **IDLE**. Dropping the request in BUSY aborts it: no ready, no write, return to **IDLE**.
- `DELAY` means `READ_DELAY` for reads and `WRITE_DELAY` for writes.
- Reads:
  - the array byte is sampled into a `READ_DELAY-1`-stage delay line at every edge;
  - `M_Rdata_ram[c] = delayed_byte | Sout_Rdata_ram[c]`;
  - the local byte is 0 when the sampled address was out of range.
- Writes commit at the edge ending the ready cycle as `mem = (wdata & mask) | (mem & ~mask)`, where:
  - `mask = (1 << size) - 1`, truncated to 8 bits;
  - size ≥ 8 gives `8'hFF`; size 0 gives no change.
- `M_DataRdy[c] = Sout_DataRdy[c] | local_ready[c]`.
- Conflict (`oe & we` on the same channel):
  - `err_conflict[c]` is set and stays set until reset;
  - the request is treated as idle, with no access and no ready.
- Both channels hitting the same byte:
  - two reads: both are served;
  - two writes completing in the same cycle: channel 1 wins;
  - a read and a write in the same cycle: the read returns the old data.
- `load_en` writes `load_data` to `mem[load_addr]` at the next edge. Addresses ≥ MEMSIZE are dropped. `load_en` has priority over a bus write to the same byte.

## Timing
- Reset state:
  - `M_DataRdy = Sout_DataRdy` (no local ready) and `M_Rdata_ram = Sout_Rdata_ram` (delay line cleared);
  - all FSMs IDLE with `cnt=0`;
  - `err_conflict = 0`;
  - array contents are not reset.
- Read with the request first seen at cycle N: ready and data are valid in cycle `N+READ_DELAY-1`. With the default this is N+1, with data registered once.
- Write with the request first seen at cycle N: ready in cycle `N+WRITE_DELAY-1`. With the default this is cycle N itself (combinational), and the write commits at the end of cycle N.
- Ready is a one-cycle pulse. The master may issue the next request in the cycle after ready. Back-to-back reads give one result every `READ_DELAY` cycles.
- Reset asserted mid-transaction: the pending access aborts with no write and no ready. The FSM is IDLE on the cycle after reset.

## Test plan
- **Preload and default read.** Preload `mem[5]=8'hA7`, then hold ch0 `oe` with addr 5 from cycle N → `M_DataRdy[0]=1` and `M_Rdata_ram[7:0]=8'hA7` at N+1; ch1 stays 0.
- **Write then read-back.** ch1 `we`, addr 3, `wdata 8'h3C`, size 8 → `M_DataRdy[1]=1` in the same cycle; a later read of addr 3 returns `8'h3C`. Repeat with size 4 over `8'hFF` → `8'hFC`.
- **Out of range.** Read addr 40 with `MEMSIZE=32` → no local ready, local data 0. Drive `Sout_DataRdy[0]=1` and `Sout_Rdata_ram=8'h11` → outputs `1` and `8'h11`.
- **Conflict.** `oe` and `we` together on ch0 → `err_conflict=2'b01` from the next cycle; the array is unchanged; the flag stays set until `reset` is pulsed.
- **Long latency.** With `READ_DELAY=4`, read at N → ready only at N+3. Drop `oe` at N+2 → no ready is ever produced.
- **Reset mid-transaction.** Assert `reset` at N+1 of a `READ_DELAY=4` read → no ready; the next read after reset completes normally.
